// File: rtl/step_ctrl_pkg.sv
// Shared types, constants and helpers for the joystick stepper ramp controller.
// Define STEP_HALF_STEP_EN to select the 8-entry half-step coil table.
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEL  = 2'd1,
    ST_CRUISE = 2'd2,
    ST_DECEL  = 2'd3
  } step_state_t;

  localparam logic [9:0] CENTER    = 10'd512;
  localparam logic [9:0] DEAD_ZONE = 10'd64;

`ifdef STEP_HALF_STEP_EN
  localparam int PHASE_W = 3;
  localparam logic [7:0][3:0] PHASE_TABLE = {4'b1001, 4'b0001, 4'b0011, 4'b0010,
                                             4'b0110, 4'b0100, 4'b1100, 4'b1000};
`else
  localparam int PHASE_W = 2;
  localparam logic [3:0][3:0] PHASE_TABLE = {4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif

  function automatic logic target_dir(input logic [9:0] data);
    return (data >= CENTER);
  endfunction

  // Deflection from centre saturated to 511; the top three bits form the level.
  function automatic logic [2:0] target_level(input logic [9:0] data);
    logic [9:0] diff;
    if (data >= CENTER) begin
      diff = data - CENTER;
    end else begin
      diff = CENTER - data;
    end
    if (diff > 10'd511) begin
      diff = 10'd511;
    end else begin
      diff = diff;
    end
    if (diff < DEAD_ZONE) begin
      return 3'd0;
    end else begin
      return diff[8:6];
    end
  endfunction

endpackage

// File: rtl/step_phase_gen.sv
// Coil phase index with wrap-around and registered coil-pattern lookup.
// The index survives IDLE; only the coil drive is blanked there.
module step_phase_gen
  import step_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  input  logic       fwd,
  input  logic       active,
  output logic [3:0] coils
);

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_next;

  // Next phase index; natural binary wrap gives the modulo table length.
  always_comb begin
    phase_next = phase;
    if (advance) begin
      if (fwd) begin
        phase_next = phase + PHASE_W'(1);
      end else begin
        phase_next = phase - PHASE_W'(1);
      end
    end else begin
      phase_next = phase;
    end
  end

  // Phase register and coil output, blanked when the axis is going idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
      coils <= 4'b0000;
    end else begin
      phase <= phase_next;
      coils <= active ? PHASE_TABLE[phase_next] : 4'b0000;
    end
  end

endmodule

// File: rtl/jstk_step_ramp_ctrl.sv
// Joystick-driven stepper controller with one-level-per-step speed ramping.
// Build option STEP_HALF_STEP_EN (see step_ctrl_pkg) selects half-step drive.
module jstk_step_ramp_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int BASE_PERIOD = 25000
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [9:0] jstk_data,
  input  logic       data_valid,
  output logic [3:0] signal_out,
  output logic       dir_out,
  output logic [2:0] cur_level,
  output logic       moving,
  output logic       step_pulse
);

  step_state_t state;
  step_state_t state_next;
  logic [9:0]  data_reg;
  logic [2:0]  level_next;
  logic        dir_next;
  logic [23:0] count;
  logic [23:0] period_m1;
  logic        tick;
  logic        tgt_dir;
  logic [2:0]  tgt_lvl;

  assign tgt_dir = target_dir(data_reg);
  assign tgt_lvl = target_level(data_reg);

  // 3'd0 - level equals 8 - level for levels 1..7; level 0 only occurs in IDLE.
  assign period_m1 = 24'(BASE_PERIOD) * {21'd0, 3'd0 - cur_level} - 24'd1;
  assign tick      = (state != ST_IDLE) && (count == period_m1);

  // Next state, level and direction; ramp decisions happen only on a tick.
  always_comb begin
    state_next = state;
    level_next = cur_level;
    dir_next   = dir_out;
    case (state)
      ST_IDLE: begin
        if (en && (tgt_lvl != 3'd0)) begin
          state_next = ST_ACCEL;
          level_next = 3'd1;
          dir_next   = tgt_dir;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ACCEL, ST_CRUISE, ST_DECEL: begin
        if (!tick) begin
          state_next = state;
        end else if (!en || (tgt_lvl == 3'd0) || (tgt_dir != dir_out)) begin
          if (cur_level <= 3'd1) begin
            state_next = ST_IDLE;
            level_next = 3'd0;
          end else begin
            state_next = ST_DECEL;
            level_next = cur_level - 3'd1;
          end
        end else if (tgt_lvl > cur_level) begin
          state_next = ST_ACCEL;
          level_next = cur_level + 3'd1;
        end else if (tgt_lvl < cur_level) begin
          state_next = ST_DECEL;
          level_next = cur_level - 3'd1;
        end else begin
          state_next = ST_CRUISE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        level_next = 3'd0;
      end
    endcase
  end

  // State, timer, sample register and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cur_level  <= 3'd0;
      dir_out    <= 1'b1;
      count      <= 24'd0;
      data_reg   <= CENTER;
      moving     <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      state      <= state_next;
      cur_level  <= level_next;
      dir_out    <= dir_next;
      count      <= ((state == ST_IDLE) || tick) ? 24'd0 : count + 24'd1;
      data_reg   <= data_valid ? jstk_data : data_reg;
      moving     <= (state_next != ST_IDLE);
      step_pulse <= tick;
    end
  end

  step_phase_gen u_phase (
    .clk     (clk),
    .rst     (rst),
    .advance (tick),
    .fwd     (dir_out),
    .active  (state_next != ST_IDLE),
    .coils   (signal_out)
  );

endmodule
